// File: rtl/deck_shuffle_ctrl_pkg.sv
// Shared constants, controller state type and card decode helpers.
package deck_shuffle_ctrl_pkg;

  localparam int unsigned DECK_SIZE = 52;
  localparam int unsigned CARD_W    = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_PICK,
    ST_RD_I,
    ST_RD_J,
    ST_WR_I,
    ST_WR_J,
    ST_READY,
    ST_DEAL_RD,
    ST_DEAL_OUT
  } state_e;

  // Rank 1..13 (ace low) of a card index.
  function automatic logic [3:0] card_rank(input logic [CARD_W-1:0] idx);
    logic [CARD_W-1:0] r;
    r = idx % CARD_W'(13);
    return 4'(r) + 4'd1;
  endfunction

  // Suit 0..3 of a card index.
  function automatic logic [1:0] card_suit(input logic [CARD_W-1:0] idx);
    logic [CARD_W-1:0] s;
    s = idx / CARD_W'(13);
    return 2'(s);
  endfunction

endpackage

// File: rtl/deck_shuffle_ctrl_if.sv
// Control handshake and deck RAM port of the shuffle controller.
interface deck_shuffle_ctrl_if #(
  parameter int unsigned CARD_W = 6
) ();
  logic              start;
  logic              deal_req;
  logic              busy;
  logic              ready;
  logic              card_valid;
  logic [CARD_W-1:0] card;
  logic              deck_empty;
  logic [CARD_W-1:0] ram_addr;
  logic [CARD_W-1:0] ram_wdata;
  logic              ram_we;
  logic [CARD_W-1:0] ram_rdata;

  // Game controller plus deck RAM side.
  modport master (
    output start, deal_req, ram_rdata,
    input  busy, ready, card_valid, card, deck_empty, ram_addr, ram_wdata, ram_we
  );

  // Shuffle controller side.
  modport slave (
    input  start, deal_req, ram_rdata,
    output busy, ready, card_valid, card, deck_empty, ram_addr, ram_wdata, ram_we
  );
endinterface

// File: rtl/deck_shuffle_ctrl_lfsr.sv
// Free-running right-shifting Galois LFSR.
module lfsr_gen #(
  parameter int unsigned        LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]  LFSR_SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0]  LFSR_TAPS = 16'hB400
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  logic [LFSR_W-1:0] q_q, q_d;

  // Next value: shift right, fold in the tap mask when a one falls out.
  always_comb begin
    q_d = q_q >> 1;
    if (q_q[0]) q_d = q_d ^ LFSR_TAPS;
  end

  // Advance every clock regardless of controller state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= LFSR_SEED;
    else      q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/deck_shuffle_ctrl.sv
// Deck RAM sequencer: fill 0..N-1, Fisher-Yates shuffle in place, deal on request.
module deck_shuffle_ctrl
  import deck_shuffle_ctrl_pkg::*;
#(
  parameter int unsigned       DECK_SIZE = 52,
  parameter int unsigned       CARD_W    = 6,
  parameter int unsigned       LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400
) (
  input logic                clk,
  input logic                rst,
  deck_shuffle_ctrl_if.slave bus
);
  localparam int unsigned PW = CARD_W + 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     i_q, i_d, j_q, j_d, ptr_q, ptr_d;
  logic [CARD_W-1:0] ti_q, ti_d, card_q, card_d;
  logic              cv_q, cv_d;
  logic [LFSR_W-1:0] lfsr;
  logic [PW-1:0]     cand;
  logic              deck_empty;
  logic              unused_lfsr_hi;

  lfsr_gen #(
    .LFSR_W   (LFSR_W),
    .LFSR_SEED(LFSR_SEED),
    .LFSR_TAPS(LFSR_TAPS)
  ) u_lfsr (
    .clk(clk),
    .rst(rst),
    .q  (lfsr)
  );

  assign cand           = {1'b0, lfsr[CARD_W-1:0]};
  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:CARD_W];
  assign deck_empty     = (ptr_q == PW'(DECK_SIZE));

  // Next state, counters and RAM strobes.
  // i doubles as the fill address during INIT; it ends at DECK_SIZE-1, which is
  // exactly the first swap index. WR_I writes the j-read straight from ram_rdata.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    ptr_d         = ptr_q;
    ti_d          = ti_q;
    card_d        = card_q;
    cv_d          = 1'b0;
    bus.busy      = 1'b0;
    bus.ready     = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_INIT;
          i_d     = '0;
          ptr_d   = '0;
        end
      end
      ST_INIT: begin
        bus.busy      = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = i_q[CARD_W-1:0];
        bus.ram_wdata = i_q[CARD_W-1:0];
        if (i_q == PW'(DECK_SIZE - 1)) state_d = ST_PICK;
        else                           i_d     = i_q + PW'(1);
      end
      ST_PICK: begin
        bus.busy = 1'b1;
        if (cand <= i_q) begin
          j_d     = cand;
          state_d = ST_RD_I;
        end
      end
      ST_RD_I: begin
        bus.busy     = 1'b1;
        bus.ram_addr = i_q[CARD_W-1:0];
        state_d      = ST_RD_J;
      end
      ST_RD_J: begin
        bus.busy     = 1'b1;
        bus.ram_addr = j_q[CARD_W-1:0];
        ti_d         = bus.ram_rdata;
        state_d      = ST_WR_I;
      end
      ST_WR_I: begin
        bus.busy      = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = i_q[CARD_W-1:0];
        bus.ram_wdata = bus.ram_rdata;
        state_d       = ST_WR_J;
      end
      ST_WR_J: begin
        bus.busy      = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = j_q[CARD_W-1:0];
        bus.ram_wdata = ti_q;
        if (i_q == PW'(1)) begin
          state_d = ST_READY;
          ptr_d   = '0;
        end else begin
          i_d     = i_q - PW'(1);
          state_d = ST_PICK;
        end
      end
      ST_READY: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          state_d = ST_INIT;
          i_d     = '0;
          ptr_d   = '0;
        end else if (bus.deal_req && !deck_empty) begin
          state_d = ST_DEAL_RD;
        end
      end
      ST_DEAL_RD: begin
        bus.ram_addr = ptr_q[CARD_W-1:0];
        state_d      = ST_DEAL_OUT;
      end
      ST_DEAL_OUT: begin
        card_d  = bus.ram_rdata;
        cv_d    = 1'b1;
        if (!deck_empty) ptr_d = ptr_q + PW'(1);
        state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters, swap register and registered card output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      ptr_q   <= '0;
      ti_q    <= '0;
      card_q  <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ptr_q   <= ptr_d;
      ti_q    <= ti_d;
      card_q  <= card_d;
      cv_q    <= cv_d;
    end
  end

  assign bus.card_valid = cv_q;
  assign bus.card       = card_q;
  assign bus.deck_empty = deck_empty;
endmodule

// File: tb/tb_deck_shuffle_ctrl.sv
// Randomized bench for deck_shuffle_ctrl with an arithmetic Fisher-Yates reference.
module tb_deck_shuffle_ctrl;
  import deck_shuffle_ctrl_pkg::*;

  localparam int DS = 52;

  logic clk;
  logic rst;

  deck_shuffle_ctrl_if #(.CARD_W(6)) bus ();

  deck_shuffle_ctrl #(
    .DECK_SIZE(52),
    .CARD_W   (6),
    .LFSR_W   (16),
    .LFSR_SEED(16'hACE1),
    .LFSR_TAPS(16'hB400)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Deck RAM: synchronous write, registered read.
  logic [5:0] mem [64];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned cyc;

  logic [5:0]  m_perm [64];
  logic [5:0]  perm2  [64];
  int unsigned m_pick_cyc [64];
  int unsigned m_ready_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference shuffle. Cycle k means the cycle after the k-th edge since reset
  // release; the LFSR shows seed stepped k times. Start sampled at edge s:
  // fill occupies cycles s..s+51, the first pick is cycle s+52, each accepted
  // pick costs 5 cycles, each rejected one costs 1.
  task automatic model_shuffle(input int unsigned s);
    logic [15:0] v;
    int unsigned t;
    int          j;
    logic [5:0]  tmp;
    v = 16'hACE1;
    for (int unsigned k = 0; k < s + DS; k++) v = lstep(v);
    t = s + DS;
    for (int k = 0; k < 64; k++) m_perm[k] = 6'(k);
    for (int i = DS - 1; i >= 1; i--) begin
      m_pick_cyc[i] = t;
      while (int'(v[5:0]) > i) begin
        v = lstep(v);
        t++;
      end
      j         = int'(v[5:0]);
      tmp       = m_perm[i];
      m_perm[i] = m_perm[j];
      m_perm[j] = tmp;
      for (int k = 0; k < 5; k++) v = lstep(v);
      t += 5;
    end
    m_ready_cyc = t;
  endtask

  task automatic check_mem(input string tag);
    int seen [64];
    int good;
    for (int k = 0; k < 64; k++) seen[k] = 0;
    for (int k = 0; k < DS; k++) begin
      chk(tag, 32'(mem[k]), 32'(m_perm[k]));
      if (mem[k] < 6'(DS)) seen[mem[k]]++;
    end
    good = 0;
    for (int k = 0; k < DS; k++) if (seen[k] == 1) good++;
    chk({tag, "_is_perm"}, 32'(good), 32'(DS));
  endtask

  // Called in the first fill cycle (cyc == start edge).
  task automatic run_shuffle(input bit busy_start_pulse, input bit deal_noise);
    int unsigned s;
    int unsigned cv_seen;
    s = cyc;
    model_shuffle(s);
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    chk("empty_clear_on_init", 32'(bus.deck_empty), 32'd0);
    cv_seen = 0;
    while (cyc < m_ready_cyc - 1) begin
      bus.start    = busy_start_pulse && (cyc == s + 10);
      bus.deal_req = deal_noise && (cyc + 3 < m_ready_cyc) && ($urandom_range(0, 1) == 1);
      tick();
      if (bus.card_valid) cv_seen++;
    end
    bus.start    = 1'b0;
    bus.deal_req = 1'b0;
    chk("ready_before_done", 32'(bus.ready), 32'd0);
    chk("busy_before_done", 32'(bus.busy), 32'd1);
    tick();
    if (bus.card_valid) cv_seen++;
    chk("ready_at_done", 32'(bus.ready), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("no_strobe_in_shuffle", 32'(cv_seen), 32'd0);
    chk("empty_at_done", 32'(bus.deck_empty), 32'd0);
  endtask

  // Pulse deal_req in READY and check the strobe two cycles later.
  task automatic deal(input bit exp_valid, input logic [5:0] exp_card, input string tag);
    bus.deal_req = 1'b1;
    tick();
    bus.deal_req = 1'b0;
    chk({tag, "_cv_n0"}, 32'(bus.card_valid), 32'd0);
    tick();
    chk({tag, "_cv_n1"}, 32'(bus.card_valid), 32'd0);
    tick();
    chk({tag, "_cv"}, 32'(bus.card_valid), 32'(exp_valid));
    if (exp_valid) chk({tag, "_card"}, 32'(bus.card), 32'(exp_card));
  endtask

  task automatic start_at(input int unsigned c);
    while (cyc < c) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    cyc          = 0;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.deal_req = 1'b0;

    // Reset state.
    repeat (3) tick();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd0);
    chk("rst_cv", 32'(bus.card_valid), 32'd0);
    chk("rst_card", 32'(bus.card), 32'd0);
    chk("rst_empty", 32'(bus.deck_empty), 32'd0);
    chk("rst_we", 32'(bus.ram_we), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'hACE1);
    rst = 1'b1;
    cyc = 0;

    // Shuffle started at edge 700, with a start pulse during the fill.
    start_at(699);
    run_shuffle(1'b1, 1'b0);
    check_mem("perm_700");
    for (int k = 0; k < 64; k++) perm2[k] = m_perm[k];

    // Deal the whole deck, then one more.
    for (int k = 0; k < DS; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      deal(1'b1, m_perm[k], "deal");
      if (k == DS - 2) chk("empty_at_51", 32'(bus.deck_empty), 32'd0);
    end
    chk("empty_at_52", 32'(bus.deck_empty), 32'd1);
    deal(1'b0, 6'd0, "deal_53");
    chk("empty_after_53", 32'(bus.deck_empty), 32'd1);
    chk("card_held", 32'(bus.card), 32'(m_perm[DS-1]));

    // Random-time reshuffle, 10 deals, then start+deal_req together.
    start_at(cyc + $urandom_range(1, 40));
    run_shuffle(1'b0, 1'b1);
    check_mem("perm_rand");
    for (int k = 0; k < 10; k++) deal(1'b1, m_perm[k], "deal10");
    bus.start    = 1'b1;
    bus.deal_req = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.deal_req = 1'b0;
    run_shuffle(1'b0, 1'b1);
    check_mem("perm_reshuf");
    for (int k = 0; k < 3; k++) deal(1'b1, m_perm[k], "deal_after_reshuf");

    // Reset during the pick for i=30, then repeat the edge-700 start.
    start_at(cyc + $urandom_range(1, 40));
    model_shuffle(cyc);
    while (cyc < m_pick_cyc[30]) tick();
    rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_ready", 32'(bus.ready), 32'd0);
    tick();
    chk("midrst_busy_edge", 32'(bus.busy), 32'd0);
    chk("midrst_we_edge", 32'(bus.ram_we), 32'd0);
    rst = 1'b1;
    cyc = 0;
    start_at(699);
    run_shuffle(1'b0, 1'b0);
    check_mem("perm_700_again");
    for (int k = 0; k < DS; k++) chk("repeat_perm", 32'(mem[k]), 32'(perm2[k]));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
